// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Register-file writeback arbiter with an issue scoreboard.
//   - Two writeback requesters (ALU, load/MEM) share one register-file write
//     port. A lone requester is granted at once; on a conflict the grant
//     alternates, starting with MEM after reset.
//   - A 32-entry busy scoreboard blocks issue of instructions whose sources,
//     or whose destination, still have a write outstanding.
//   - stall_cnt counts the cycles an instruction was presented but blocked.
//     It saturates at all-ones.
//
// Ports
//   clk, reset                      clock, asynchronous active-low reset
//   iss_valid/rs1/rs2/rd/wr         issue request
//   iss_ready (comb)                issue may proceed this cycle
//   alu_valid/rd/data, alu_ready    ALU writeback request / grant (comb)
//   mem_valid/rd/data, mem_ready    load writeback request / grant (comb)
//   rf_RegWrite/rf_rd/rf_WriteData  registered register-file write port
//   busy                            registered scoreboard (bit 0 always 0)
//   stall_cnt                       registered saturating stall counter
//
// Configuration
//   WB_BYPASS_EN  when defined, a busy bit being cleared by this cycle's
//                 grant is already treated as free by iss_ready.
module regfile_wb_arbiter #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iss_valid,
    input  logic [4:0]       iss_rs1,
    input  logic [4:0]       iss_rs2,
    input  logic [4:0]       iss_rd,
    input  logic             iss_wr,
    output logic             iss_ready,
    input  logic             alu_valid,
    input  logic [4:0]       alu_rd,
    input  logic [XLEN-1:0]  alu_data,
    output logic             alu_ready,
    input  logic             mem_valid,
    input  logic [4:0]       mem_rd,
    input  logic [XLEN-1:0]  mem_data,
    output logic             mem_ready,
    output logic             rf_RegWrite,
    output logic [4:0]       rf_rd,
    output logic [XLEN-1:0]  rf_WriteData,
    output logic [31:0]      busy,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [31:0]      busy_q, busy_d, busy_eff, clr_mask, set_mask;
    logic             rr_alu_last_q, rr_alu_last_d;
    logic             live_q;
    logic             we_q, we_d;
    logic [4:0]       rd_q, rd_d;
    logic [XLEN-1:0]  data_q, data_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             gnt, accept;
    logic [4:0]       gnt_rd;
    logic [XLEN-1:0]  gnt_data;

    always_comb begin
        // No grant in the first cycle out of reset, so the first edge after
        // deassertion never produces a write.
        mem_ready = live_q & mem_valid & (~alu_valid | rr_alu_last_q);
        alu_ready = live_q & alu_valid & (~mem_valid | ~rr_alu_last_q);
        gnt       = alu_ready | mem_ready;
        gnt_rd    = mem_ready ? mem_rd   : alu_rd;
        gnt_data  = mem_ready ? mem_data : alu_data;
        clr_mask  = gnt ? (32'd1 << gnt_rd) : 32'd0;

`ifdef WB_BYPASS_EN
        busy_eff  = busy_q & ~clr_mask;
`else
        busy_eff  = busy_q;
`endif

        iss_ready = ~(busy_eff[iss_rs1] | busy_eff[iss_rs2] | (iss_wr & busy_eff[iss_rd]));
        accept    = iss_valid & iss_ready;
        set_mask  = (accept && iss_wr) ? (32'd1 << iss_rd) : 32'd0;
        // Set is applied after clear so a same-cycle re-issue keeps the bit.
        busy_d    = ((busy_q & ~clr_mask) | set_mask) & ~32'd1;

        // Pointer moves only when both asked and one actually won.
        rr_alu_last_d = (alu_valid && mem_valid && gnt) ? alu_ready : rr_alu_last_q;

        we_d   = gnt && (gnt_rd != 5'd0);
        rd_d   = we_d ? gnt_rd   : rd_q;
        data_d = we_d ? gnt_data : data_q;

        stall_d = stall_q;
        if (iss_valid && !iss_ready && (stall_q != {CNT_W{1'b1}}))
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q        <= '0;
            rr_alu_last_q <= 1'b1;
            live_q        <= 1'b0;
            we_q          <= 1'b0;
            rd_q          <= '0;
            data_q        <= '0;
            stall_q       <= '0;
        end else begin
            busy_q        <= busy_d;
            rr_alu_last_q <= rr_alu_last_d;
            live_q        <= 1'b1;
            we_q          <= we_d;
            rd_q          <= rd_d;
            data_q        <= data_d;
            stall_q       <= stall_d;
        end
    end

    assign busy         = busy_q;
    assign rf_RegWrite  = we_q;
    assign rf_rd        = rd_q;
    assign rf_WriteData = data_q;
    assign stall_cnt    = stall_q;

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, the writeback data width.
REQ-002 The block SHALL have parameter CNT_W, default 16, the stall counter width.
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 Port iss_valid  input  1  issue stage presents an instruction.
REQ-006 Port iss_rs1, iss_rs2  input  5 each  source register indices.
REQ-007 Port iss_rd  input  5  destination register index.
REQ-008 Port iss_wr  input  1  the instruction writes iss_rd.
REQ-009 Port iss_ready  output  1  combinational; the instruction may issue this cycle.
REQ-010 Port alu_valid / mem_valid  input  1 each  writeback request from the ALU / load path.
REQ-011 Port alu_rd / mem_rd  input  5 each; alu_data / mem_data  input  XLEN each.
REQ-012 Port alu_ready / mem_ready  output  1 each  combinational grant.
REQ-013 Port rf_RegWrite  output  1; rf_rd  output  5; rf_WriteData  output  XLEN  registered register-file write port.
REQ-014 Port busy  output  32  registered scoreboard, bit n = register n has a pending write.
REQ-015 Port stall_cnt  output  CNT_W  registered, saturating count of stalled issue cycles.

Function
REQ-016 Issue SHALL be accepted when iss_valid && iss_ready.
REQ-017 iss_ready SHALL be 0 when busy[iss_rs1], busy[iss_rs2], or (iss_wr && busy[iss_rd]) is set, and 1 otherwise.
REQ-018 An accepted issue with iss_wr=1 and iss_rd!=0 SHALL set busy[iss_rd] at the next edge.
REQ-019 busy[0] SHALL be constant 0.
REQ-020 Single valid writeback requester SHALL be granted in the same cycle.
REQ-021 When both requesters are valid, the grant SHALL go round-robin: the requester not granted last; after reset, MEM wins the first conflict.
REQ-022 The round-robin pointer SHALL update only on a conflict cycle.
REQ-023 A granted request SHALL appear on rf_RegWrite/rf_rd/rf_WriteData at the next edge (1-cycle latency).
REQ-024 rf_RegWrite SHALL be 1 for exactly one cycle per grant, and SHALL be 0 when the granted rd is 0 or there is no grant.
REQ-025 rf_rd and rf_WriteData SHALL hold their last values when rf_RegWrite is 0.
REQ-026 A grant SHALL clear busy[granted rd] at the next edge.
REQ-027 If an issue accepts rd=n in the same cycle as a grant clears n, busy[n] SHALL end up set (set wins).
REQ-028 stall_cnt SHALL increment on each cycle with iss_valid && !iss_ready, and SHALL saturate at all-ones.

Reset
REQ-029 While reset=0, the outputs SHALL be: busy=0, rf_RegWrite=0, rf_rd=0, rf_WriteData=0, stall_cnt=0, round-robin pointer=ALU-last.
REQ-030 Reset assertion mid-operation SHALL discard pending grants and scoreboard state immediately, without waiting for a clock.
REQ-031 On the first edge after deassertion, no writes SHALL be emitted.

Configuration
REQ-032 With macro WB_BYPASS_EN defined, a register whose busy bit is being cleared by a grant in the current cycle SHALL count as not busy for iss_ready (same-cycle release).
REQ-033 Without WB_BYPASS_EN, iss_ready SHALL use the registered busy value only, so a waiting instruction issues one cycle after the clearing grant.

Verification
REQ-034 Reset, then issue rs1=1, rs2=2, rd=5, wr=1 -> iss_ready=1; busy=0x00000020 next cycle; stall_cnt=0.
REQ-035 With busy[5] set, issue rs1=5 -> iss_ready=0; stall_cnt increments by 1 per cycle; ALU write rd=5, data=0xAB -> next cycle rf_RegWrite=1, rf_rd=5, rf_WriteData=0xAB, busy[5]=0; iss_ready=1 on the same cycle as the grant if WB_BYPASS_EN is defined, one cycle later if it is not.
REQ-036 ALU and MEM both valid for 3 cycles, rd=3 and 4 -> grants MEM, ALU, MEM; mem_ready/alu_ready are mutually exclusive; three consecutive rf_RegWrite pulses.
REQ-037 MEM write with rd=0, data=0xFF -> mem_ready=1; rf_RegWrite stays 0; busy unchanged.
REQ-038 Issue rd=7 accepted in the same cycle as an ALU grant clearing rd=7 -> busy[7]=1 afterwards.
REQ-039 Assert reset between grant and output edge -> rf_RegWrite=0, busy=0 immediately; force stall for 2^CNT_W+5 cycles -> stall_cnt holds at all-ones.
